dds_sweep_ctrl: RTL and testbench

- Sequencer that configures one `dds` instance by driving `dds_en`, `dds_fword` and `dds_pword`.
- Produces linear frequency sweeps in three modes: single, sawtooth repeat, triangle.
- Sweep limits, step size and dwell time come from a small register write port. They are latched into active copies at `start`.
- Sits between the control/config logic and the DDS. It runs in the DDS clock domain, e.g. 100 MHz, so 42949672 ≈ 1 MHz.

---
 rtl/dds_sweep_pkg.sv | 25 ++
 rtl/dds_dwell_cnt.sv | 28 ++
 rtl/dds_sweep_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared types and register map for the DDS frequency-sweep sequencer.
package dds_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    // Encoding 3 behaves exactly like single.
    typedef enum logic [1:0] {
        MODE_SINGLE     = 2'd0,
        MODE_SAW        = 2'd1,
        MODE_TRI        = 2'd2,
        MODE_SINGLE_ALT = 2'd3
    } mode_t;

    localparam logic [2:0] ADDR_FSTART = 3'd0;
    localparam logic [2:0] ADDR_FSTOP  = 3'd1;
    localparam logic [2:0] ADDR_FSTEP  = 3'd2;
    localparam logic [2:0] ADDR_DWELL  = 3'd3;
    localparam logic [2:0] ADDR_PWORD  = 3'd4;
    localparam logic [2:0] ADDR_MODE   = 3'd5;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable dwell down-counter; tick marks the last cycle of a frequency's dwell.
module dds_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    // The owner reloads on every tick, so the counter never has to wrap itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt > W'(1))) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = en && (cnt == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving a DDS (single, sawtooth, triangle).
// cfg_we/start/stop are single-cycle strobes with no back-pressure; start is honoured only in IDLE and stop always wins.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int FW_W    = 32,
    parameter int PW_W    = 12,
    parameter int DWELL_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    input  logic            start,
    input  logic            stop,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic            step_strobe,
    output logic            sweep_dir,
    output logic            dds_en,
    output logic [FW_W-1:0] dds_fword,
    output logic [PW_W-1:0] dds_pword
);

    state_t state, state_n;

    logic [FW_W-1:0]    sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [PW_W-1:0]    sh_pword;
    mode_t              sh_mode;

    logic [FW_W-1:0]    a_start, a_stop, a_step;
    logic [DWELL_W-1:0] a_dwell;
    mode_t              a_mode;

    logic [FW_W-1:0]    fword_n;
    logic [PW_W-1:0]    pword_n;
    logic               en_n, busy_n, done_n, err_n, strobe_n, dir_n;
    logic               latch, load, tick;
    logic [DWELL_W-1:0] sh_dwell_eff, dwell_load;
    logic [FW_W:0]      nxt_up, nxt_dn;
    logic [FW_W-1:0]    up_val, dn_val;

    assign sh_dwell_eff = (sh_dwell == '0) ? DWELL_W'(1) : sh_dwell;
    assign dwell_load   = latch ? sh_dwell_eff : a_dwell;

    dds_dwell_cnt #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .load     (load),
        .load_val (dwell_load),
        .tick     (tick)
    );

    // One extra bit catches the carry/borrow so wrap-around clamps to the limit.
    assign nxt_up = {1'b0, dds_fword} + {1'b0, a_step};
    assign nxt_dn = {1'b0, dds_fword} - {1'b0, a_step};
    assign up_val = (nxt_up[FW_W] || (nxt_up[FW_W-1:0] >= a_stop))  ? a_stop  : nxt_up[FW_W-1:0];
    assign dn_val = (nxt_dn[FW_W] || (nxt_dn[FW_W-1:0] <= a_start)) ? a_start : nxt_dn[FW_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        fword_n  = dds_fword;
        pword_n  = dds_pword;
        en_n     = dds_en;
        busy_n   = busy;
        dir_n    = sweep_dir;
        done_n   = 1'b0;
        err_n    = 1'b0;
        strobe_n = 1'b0;
        latch    = 1'b0;
        load     = 1'b0;
        if (stop) begin
            state_n = IDLE;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            dir_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if ((sh_step == '0) || (sh_start > sh_stop)) begin
                            err_n = 1'b1;
                        end else begin
                            state_n  = UP;
                            latch    = 1'b1;
                            load     = 1'b1;
                            fword_n  = sh_start;
                            pword_n  = sh_pword;
                            en_n     = 1'b1;
                            busy_n   = 1'b1;
                            strobe_n = 1'b1;
                            dir_n    = 1'b0;
                        end
                    end
                end
                UP: begin
                    if (tick) begin
                        if (dds_fword == a_stop) begin
                            case (a_mode)
                                MODE_SAW: begin
                                    fword_n  = a_start;
                                    strobe_n = 1'b1;
                                    load     = 1'b1;
                                end
                                MODE_TRI: begin
                                    state_n  = DOWN;
                                    dir_n    = 1'b1;
                                    fword_n  = dn_val;
                                    strobe_n = 1'b1;
                                    load     = 1'b1;
                                end
                                default: begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                    busy_n  = 1'b0;
                                    en_n    = 1'b0;
                                end
                            endcase
                        end else begin
                            fword_n  = up_val;
                            strobe_n = 1'b1;
                            load     = 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (tick) begin
                        if (dds_fword == a_start) begin
                            state_n = UP;
                            dir_n   = 1'b0;
                            fword_n = up_val;
                        end else begin
                            fword_n = dn_val;
                        end
                        strobe_n = 1'b1;
                        load     = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_start    <= '0;
            sh_stop     <= '0;
            sh_step     <= '0;
            sh_dwell    <= '0;
            sh_pword    <= '0;
            sh_mode     <= MODE_SINGLE;
            a_start     <= '0;
            a_stop      <= '0;
            a_step      <= '0;
            a_dwell     <= '0;
            a_mode      <= MODE_SINGLE;
            dds_fword   <= '0;
            dds_pword   <= '0;
            dds_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            step_strobe <= 1'b0;
            sweep_dir   <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_FSTART: sh_start <= FW_W'(cfg_wdata);
                    ADDR_FSTOP:  sh_stop  <= FW_W'(cfg_wdata);
                    ADDR_FSTEP:  sh_step  <= FW_W'(cfg_wdata);
                    ADDR_DWELL:  sh_dwell <= DWELL_W'(cfg_wdata);
                    ADDR_PWORD:  sh_pword <= PW_W'(cfg_wdata);
                    ADDR_MODE:   sh_mode  <= mode_t'(cfg_wdata[1:0]);
                    default: ;
                endcase
            end
            if (latch) begin
                a_start <= sh_start;
                a_stop  <= sh_stop;
                a_step  <= sh_step;
                a_dwell <= sh_dwell_eff;
                a_mode  <= sh_mode;
            end
            dds_fword   <= fword_n;
            dds_pword   <= pword_n;
            dds_en      <= en_n;
            busy        <= busy_n;
            done        <= done_n;
            cfg_err     <= err_n;
            step_strobe <= strobe_n;
            sweep_dir   <= dir_n;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: strobed frequency words are scored against an expected queue.
module tb_dds_sweep_ctrl;
    import dds_sweep_pkg::*;

    localparam int FW_W    = 32;
    localparam int PW_W    = 12;
    localparam int DWELL_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [2:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic            start;
    logic            stop;
    logic            busy, done, cfg_err, step_strobe, sweep_dir, dds_en;
    logic [FW_W-1:0] dds_fword;
    logic [PW_W-1:0] dds_pword;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int exp_gap  = 1;
    int done_cnt = 0;
    bit have_last = 1'b0;
    logic [FW_W:0] exp_q[$];
    logic [FW_W:0] exp_e;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.FW_W(FW_W), .PW_W(PW_W), .DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .step_strobe (step_strobe),
        .sweep_dir   (sweep_dir),
        .dds_en      (dds_en),
        .dds_fword   (dds_fword),
        .dds_pword   (dds_pword)
    );

    // Scoreboard: every strobe pops one {dir, fword} and checks the dwell gap.
    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (step_strobe) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL strobe_unexpected got %0h required none", dds_fword);
            end
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                checks++;
                assert ({sweep_dir, dds_fword} === exp_e) else begin
                    errors++;
                    $error("FAIL dir_fword got %0h required %0h", {sweep_dir, dds_fword}, exp_e);
                end
            end
            if (have_last) begin
                checks++;
                assert ((cyc - last_cyc) == exp_gap) else begin
                    errors++;
                    $error("FAIL dwell_gap got %0d required %0d", cyc - last_cyc, exp_gap);
                end
            end
            have_last = 1'b1;
            last_cyc  = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic push(input logic dir, input logic [FW_W-1:0] val);
        exp_q.push_back({dir, val});
    endtask

    task automatic pulse_start();
        have_last = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc, output int busy_cyc, output bit seen);
        busy_cyc = 0;
        seen     = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
            step();
        end
    endtask

    initial begin
        int  bcyc;
        bit  seen;
        int  d0;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; stop = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_en", dds_en, 0);
        chk("rst_fword", dds_fword, 0);
        chk("rst_pword", dds_pword, 0);
        chk("rst_flags", {done, cfg_err, step_strobe, sweep_dir}, 0);
        step();
        rst = 1'b0;
        step();

        // Single up-sweep, 11 values with dwell 4
        cfg_wr(ADDR_FSTART, 32'd42949672);
        cfg_wr(ADDR_FSTOP,  32'd429496729);
        cfg_wr(ADDR_FSTEP,  32'd42949672);
        cfg_wr(ADDR_DWELL,  32'd4);
        cfg_wr(ADDR_PWORD,  32'hABC);
        cfg_wr(ADDR_MODE,   32'd0);
        for (int k = 1; k <= 10; k++) push(1'b0, 32'(k * 42949672));
        push(1'b0, 32'd429496729);
        exp_gap = 4;
        d0 = done_cnt;
        pulse_start();
        chk("t1_pword", dds_pword, 12'hABC);
        chk("t1_en", dds_en, 1);
        run_until_done(100, bcyc, seen);
        chk("t1_done_seen", seen, 1);
        chk("t1_busy_cycles", bcyc, 44);
        chk("t1_final_fword", dds_fword, 32'd429496729);
        chk("t1_en_off", dds_en, 0);
        chk("t1_done_one_cycle", done, 0);
        chk("t1_done_count", done_cnt - d0, 1);

        // Rejected starts
        cfg_wr(ADDR_FSTEP, 32'd0);
        pulse_start();
        chk("t3_err_step0", cfg_err, 1);
        chk("t3_busy_step0", busy, 0);
        chk("t3_fword_held", dds_fword, 32'd429496729);
        step();
        chk("t3_err_pulse", cfg_err, 0);
        cfg_wr(ADDR_FSTEP,  32'd20);
        cfg_wr(ADDR_FSTART, 32'd500);
        cfg_wr(ADDR_FSTOP,  32'd400);
        pulse_start();
        chk("t3_err_order", cfg_err, 1);
        chk("t3_busy_order", busy, 0);
        chk("t3_en_order", dds_en, 0);
        step();
        chk("t3_err_pulse2", cfg_err, 0);

        // Triangle 100..130 step 20, dwell 1, then stop
        cfg_wr(ADDR_FSTART, 32'd100);
        cfg_wr(ADDR_FSTOP,  32'd130);
        cfg_wr(ADDR_DWELL,  32'd1);
        cfg_wr(ADDR_MODE,   32'd2);
        push(1'b0, 32'd100); push(1'b0, 32'd120); push(1'b0, 32'd130);
        push(1'b1, 32'd110); push(1'b1, 32'd100); push(1'b0, 32'd120);
        exp_gap = 1;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        chk("t2_last_val", {sweep_dir, dds_fword}, {1'b0, 32'd120});
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_stop_en", dds_en, 0);
        chk("t2_stop_busy", busy, 0);
        chk("t2_stop_strobe", step_strobe, 0);
        step();
        chk("t2_no_done", done_cnt - d0, 0);

        // Sawtooth with carry clamp; a start while busy is ignored
        cfg_wr(ADDR_FSTART, 32'hFFFFFF00);
        cfg_wr(ADDR_FSTOP,  32'hFFFFFFF0);
        cfg_wr(ADDR_FSTEP,  32'h100);
        cfg_wr(ADDR_DWELL,  32'd2);
        cfg_wr(ADDR_MODE,   32'd1);
        push(1'b0, 32'hFFFFFF00); push(1'b0, 32'hFFFFFFF0); push(1'b0, 32'hFFFFFF00);
        exp_gap = 2;
        pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_busy_start_no_err", cfg_err, 0);
        chk("t4_clamp_val", dds_fword, 32'hFFFFFFF0);
        step();
        step();
        chk("t4_reload_strobe", step_strobe, 1);
        chk("t4_reload_val", dds_fword, 32'hFFFFFF00);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        // Shadow write mid-sweep only affects the next start
        cfg_wr(ADDR_FSTART, 32'd100);
        cfg_wr(ADDR_FSTOP,  32'd400);
        cfg_wr(ADDR_FSTEP,  32'd100);
        cfg_wr(ADDR_DWELL,  32'd0);
        cfg_wr(ADDR_MODE,   32'd3);
        for (int k = 1; k <= 4; k++) push(1'b0, 32'(k * 100));
        exp_gap = 1;
        pulse_start();
        cfg_wr(ADDR_FSTOP, 32'd1000);
        run_until_done(50, bcyc, seen);
        chk("t5_done_seen", seen, 1);
        chk("t5_busy_cycles", bcyc, 3);
        chk("t5_final_old", dds_fword, 32'd400);
        for (int k = 1; k <= 10; k++) push(1'b0, 32'(k * 100));
        pulse_start();
        run_until_done(50, bcyc, seen);
        chk("t5_done_seen2", seen, 1);
        chk("t5_busy_cycles2", bcyc, 10);
        chk("t5_final_new", dds_fword, 32'd1000);

        // start and stop together, then reset mid-sweep
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("t6_contention_busy", busy, 0);
        chk("t6_contention_en", dds_en, 0);
        chk("t6_contention_flags", {step_strobe, cfg_err}, 0);
        step();
        chk("t6_contention_busy2", busy, 0);
        push(1'b0, 32'd100);
        pulse_start();
        step();
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_en", dds_en, 0);
        chk("t6_rst_fword", dds_fword, 0);
        chk("t6_rst_pword", dds_pword, 0);
        chk("t6_rst_flags", {done, cfg_err, step_strobe, sweep_dir}, 0);
        step();
        rst = 1'b0;
        step();
        pulse_start();
        chk("t6_shadow_cleared_err", cfg_err, 1);
        chk("t6_shadow_cleared_busy", busy, 0);
        step();

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
